// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package key_pkg;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_PRESSED,
        DB_RELEASE_WAIT
    } debounce_state_t;

    // 10 ms of stability at a 50 MHz system clock
    localparam int unsigned DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/key_conditioner_if.sv
// Board-side bundle: raw active-low keys in, conditioned counter controls out.
interface key_conditioner_if;

    logic [1:0] key_n;
    logic       preload_combine;
    logic       reverse_combine;
    logic [1:0] key_state;

    // master: the board/pin side that presents the raw keys
    modport master (
        output key_n,
        input  preload_combine,
        input  reverse_combine,
        input  key_state
    );

    // slave: the conditioner itself
    modport slave (
        input  key_n,
        output preload_combine,
        output reverse_combine,
        output key_state
    );

endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, debounce FSM with saturating stability counter.
// press_o is high in the cycle whose closing edge moves the FSM into DB_PRESSED.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            s_pressed;
    debounce_state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            level_q;

    assign s_pressed = ~sync2_q;

    // Driven only from registers, so the top can register it without a key_n path.
    assign press_o = (state_q == DB_PRESS_WAIT) && s_pressed && (cnt_q == CNT_MAX);
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            case (state_q)
                DB_IDLE: begin
                    if (s_pressed) begin
                        state_q <= DB_PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!s_pressed) begin
                        state_q <= DB_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= DB_PRESSED;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DB_PRESSED: begin
                    if (!s_pressed) begin
                        state_q <= DB_RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                DB_RELEASE_WAIT: begin
                    // A re-press here is still the same press: no new event.
                    if (s_pressed) begin
                        state_q <= DB_PRESSED;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= DB_IDLE;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= DB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Turns two bouncing active-low keys into a one-cycle preload strobe and a
// direction level for the up/down counter; all outputs registered.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic               clock_in,
    input  logic               reset_n,
    key_conditioner_if.slave   bus
);

    logic [1:0] press;
    logic [1:0] level;
    logic       preload_q;
    logic       reverse_q;

    for (genvar i = 0; i < 2; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i   (clock_in),
            .rst_ni  (reset_n),
            .key_n_i (bus.key_n[i]),
            .level_o (level[i]),
            .press_o (press[i])
        );
    end

    // Strobe and toggle land on the same edge the FSM accepts the press.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            preload_q <= 1'b1;
            reverse_q <= 1'b1;
        end else begin
            preload_q <= ~press[0];
            if (press[1]) begin
                reverse_q <= ~reverse_q;
            end
        end
    end

    assign bus.preload_combine = preload_q;
    assign bus.reverse_combine = reverse_q;
    assign bus.key_state       = level;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions the two raw, bouncing, active-low push-buttons on the board into the clean active-low control inputs the up/down counter consumes. Key 0 produces a one-cycle active-low preload strobe; key 1 toggles the count direction on each press. The block sits between the board pins and the counter, in the same clock domain, so the counter only ever sees synchronized, debounced, single-event controls.

## Interface
- DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles required to accept a press or release (10 ms at 50 MHz); legal range ≥ 2
- clock_in  input  1  system clock; all logic on rising edge
- reset_n  input  1  one clock; reset is synchronous and active-low
- key_n  input  2  raw asynchronous push-buttons, low = pressed; [0] preload, [1] reverse
- preload_combine  output  1  active-low strobe, low for exactly one cycle per accepted key 0 press
- reverse_combine  output  1  direction level, 1 = count up, 0 = count down; toggles per accepted key 1 press
- key_state  output  2  debounced key level, 1 = pressed (debug/LED use)

## Operation
- Per key: 2-flop synchronizer → debounce FSM with counter of width $clog2(DEBOUNCE_CYCLES).
- FSM states and transitions (s = synchronized key, pressed when low):
  - DB_IDLE: s pressed → DB_PRESS_WAIT, cnt ← 0.
  - DB_PRESS_WAIT: s released → DB_IDLE; else if cnt == DEBOUNCE_CYCLES-1 → DB_PRESSED, raise press event; else cnt++.
  - DB_PRESSED: s released → DB_RELEASE_WAIT, cnt ← 0.
  - DB_RELEASE_WAIT: s pressed → DB_PRESSED (no new event); else if cnt == DEBOUNCE_CYCLES-1 → DB_IDLE; else cnt++.
- key_state[i] = 1 in DB_PRESSED and DB_RELEASE_WAIT, else 0 (registered).
- Press event key 0: preload_combine driven 0 for one cycle, then 1. Holding the key produces no further strobes.
- Press event key 1: reverse_combine ← ~reverse_combine. Release has no effect.
- Keys independent; simultaneous events both take effect in the same cycle (downstream gives preload priority).
- Bounce shorter than DEBOUNCE_CYCLES during wait states restarts the attempt; never produces an event.
- Counter saturates by construction (never passes DEBOUNCE_CYCLES-1); no wrap.

## Timing
- Reset (sampled low at a rising edge): both FSMs → DB_IDLE, cnt ← 0, synchronizer flops ← 1, preload_combine = 1, reverse_combine = 1, key_state = 2'b00. Reset mid-debounce abandons the attempt; direction returns to up.
- Latency: key_n[i] low and stable before edge 0 → FSM enters DB_PRESS_WAIT at edge 2 → event registered at edge DEBOUNCE_CYCLES+2; preload_combine low from edge D+2 to edge D+3; reverse_combine and key_state change at edge D+2.
- Release: key_state falls DEBOUNCE_CYCLES+2 edges after key_n goes stably high.
- All outputs registered; no combinational path from key_n.

## Structure
- Package key_pkg: typedef enum logic [1:0] debounce_state_t {DB_IDLE, DB_PRESS_WAIT, DB_PRESSED, DB_RELEASE_WAIT}; localparam DEBOUNCE_DEFAULT = 500000.
- Sub-module key_debounce (one key: synchronizer, FSM, counter; outputs level and one-cycle press pulse), instantiated twice; top adds the preload inversion and reverse toggle flop.

## Test plan (DEBOUNCE_CYCLES = 4)
- Reset: hold reset_n low 3 cycles with keys random → preload_combine = 1, reverse_combine = 1, key_state = 00 from first reset edge.
- Clean press key 0 held 20 cycles → preload_combine low exactly one cycle, edges 6–7 after first low sample; key_state[0] = 1 from edge 6; no second strobe.
- Two clean presses of key 1 → reverse_combine 1→0 at first accept, 0→1 at second; preload_combine stays 1.
- Bounce key 0: low 3 cycles, high 1, low 3, high → no strobe, key_state stays 0; then held low 10 cycles → one strobe.
- Both keys pressed same cycle → preload strobe and reverse toggle at the same edge.
- Reset asserted during DB_PRESS_WAIT of key 1 after a prior toggle (reverse = 0) → reverse_combine = 1 after reset edge, no event when reset releases with key still bouncing < 4 cycles.
